operand_negate: RTL and testbench

OPERAND_NEGATE -- requirements
Module: operand_negate

---
 rtl/operand_negate_pkg.sv | 8 +
 rtl/chunk_negate.sv | 12 +
 rtl/operand_negate.sv | 70 +++++++
 tb/tb_operand_negate.sv | 119 +++++++++++
 4 files changed

// File: rtl/operand_negate_pkg.sv
// operand_negate_pkg: mode encodings and FSM states shared by the operand_negate slice
package operand_negate_pkg;
    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NOT  = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_ABS  = 2'b11;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/chunk_negate.sv
// chunk_negate: one CHUNK-bit slice of optional inversion plus carry-in increment
module chunk_negate #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic             invert,
    input  logic             carry_in,
    output logic [CHUNK-1:0] result,
    output logic             carry_out
);
    assign {carry_out, result} = {1'b0, invert ? ~chunk : chunk} + {{CHUNK{1'b0}}, carry_in};
endmodule

// File: rtl/operand_negate.sv
// operand_negate: chunk-serial PASS/NOT/NEG/ABS of a latched operand, one chunk per cycle
module operand_negate
    import operand_negate_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_operandA,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    state_t state, state_nxt;
    logic [WIDTH-1:0] opnd;
    logic [IW-1:0]    idx;
    logic             invert, carry, ovf_pend, neg_req, carry_out;
    logic [CHUNK-1:0] chunk_res;
    // ABS resolves to NEG or PASS from the operand's sign as it is accepted
    assign neg_req = mode == MODE_NEG || (mode == MODE_ABS && data_operandA[WIDTH-1]);
    chunk_negate #(.CHUNK(CHUNK)) u_chunk (
        .chunk     (opnd[idx*CHUNK +: CHUNK]),
        .invert    (invert),
        .carry_in  (carry),
        .result    (chunk_res),
        .carry_out (carry_out)
    );
    // next-state and status outputs
    always_comb begin
        state_nxt = state == IDLE ? (start ? BUSY : IDLE) :
                    state == BUSY ? (idx == LAST ? DONE : BUSY) : IDLE;
        ready     = state == IDLE;
        done      = state == DONE;
    end
    // state register, operand latch and per-chunk datapath with registered carry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            opnd        <= '0;
            idx         <= '0;
            invert      <= 1'b0;
            carry       <= 1'b0;
            ovf_pend    <= 1'b0;
            data_result <= '0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                opnd     <= data_operandA;
                idx      <= '0;
                invert   <= mode == MODE_NOT || neg_req;
                carry    <= neg_req;
                ovf_pend <= neg_req && data_operandA == MIN_NEG;
            end else if (state == BUSY) begin
                data_result[idx*CHUNK +: CHUNK] <= chunk_res;
                carry <= carry_out;
                idx   <= idx + IW'(1);
                if (idx == LAST) overflow <= ovf_pend;
            end
        end
    end
endmodule

// File: tb/tb_operand_negate.sv
// tb_operand_negate: directed vectors checked against an arithmetic reference model
module tb_operand_negate;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] data_operandA = '0;
    logic        ready, done, overflow;
    logic [31:0] data_result;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        armed = 1'b0;
    logic [31:0] exp_res = '0;
    logic        exp_ovf = 1'b0;

    operand_negate #(.WIDTH(32), .CHUNK(8)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .data_operandA(data_operandA), .ready(ready), .done(done),
        .data_result(data_result), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [1:0] m, input logic [31:0] a);
        logic neg;
        logic [31:0] r;
        neg = m == 2'b10 || (m == 2'b11 && a[31]);
        r = m == 2'b00 ? a : m == 2'b01 ? ~a : neg ? -a : a;
        return {neg && a == 32'h8000_0000, r};
    endfunction

    // result/overflow check on every done pulse
    always @(negedge clock) begin
        if (done) begin
            if (!armed) chk("unexpected_done", 32'(done), 32'd0);
            else begin
                chk("result", data_result, exp_res);
                chk("overflow", 32'(overflow), 32'(exp_ovf));
            end
        end
    end

    task automatic run_op(input logic [1:0] m, input logic [31:0] a,
                          input logic [31:0] lit_res, input logic lit_ovf, input bit poke);
        logic [32:0] mv;
        int cyc;
        mv = model(m, a);
        chk("model_res", mv[31:0], lit_res);
        chk("model_ovf", 32'(mv[32]), 32'(lit_ovf));
        @(negedge clock);
        chk("ready_idle", 32'(ready), 32'd1);
        start = 1'b1; mode = m; data_operandA = a;
        exp_res = mv[31:0]; exp_ovf = mv[32]; armed = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
            if (done) break;
            if (ready) break;
            if (poke && cyc == 1) begin
                start = 1'b1; mode = 2'b00; data_operandA = 32'h1234_5678;
            end else start = 1'b0;
        end
        start = 1'b0;
        chk("latency", cyc, 32'd4);
        @(posedge clock); #1;
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("ready_after_done", 32'(ready), 32'd1);
        chk("result_held", data_result, lit_res);
        armed = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", data_result, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clock); reset = 1'b0;
        run_op(2'b10, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        run_op(2'b11, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        run_op(2'b11, 32'hFFFF_FF00, 32'h0000_0100, 1'b0, 1'b0);
        run_op(2'b11, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0);
        run_op(2'b01, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b1);
        run_op(2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op(2'b00, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
        @(negedge clock);
        start = 1'b1; mode = 2'b10; data_operandA = 32'h0000_0055;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", data_result, 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            chk("no_done_after_abort", 32'(done), 32'd0);
        end
        run_op(2'b10, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
